// File: rtl/hsv_core_pkg.sv
// Shared types and helpers for the hsv_core flush path.
package hsv_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    HOLD  = 2'd2,
    EXIT  = 2'd3
  } flush_state_t;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hsv_core_flush_ctrl.sv
// Flush sequencer: broadcasts flush_req, waits for every unit to enter and leave flush, then pulses a
// one-cycle fetch redirect. Triggers are refused (ready low) for the whole sequence.
module hsv_core_flush_ctrl
  import hsv_core_pkg::*;
#(
  parameter int          NUM_UNITS      = 5,
  parameter int          HOLD_CYCLES    = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 trigger_valid_i,
  output logic                 trigger_ready_o,
  input  logic [31:0]          trigger_pc,
  output logic                 flush_req,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc,
  output logic                 flushing_o,
  output logic                 timeout_o
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int WW = cnt_width(TIMEOUT_CYCLES);

  flush_state_t  state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          redir_q, redir_d;
  logic          timeout_q, timeout_d;

  // Reset lands in ENTER so the post-reset flush runs without a trigger.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q    <= ENTER;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      pc_q       <= RESET_PC;
      redir_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pc_d       = pc_q;
    redir_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_valid_i) begin
          pc_d    = trigger_pc;
          state_d = ENTER;
        end
      end
      ENTER: begin
        if (&flush_ack) begin
          hold_cnt_d = HW'(HOLD_CYCLES - 1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = EXIT;
        else hold_cnt_d = hold_cnt_q - HW'(1);
      end
      EXIT: begin
        if (~|flush_ack) begin
          state_d = IDLE;
          redir_d = 1'b1;
        end
      end
      default: state_d = ENTER;
    endcase

    // Wait counter only measures the handshake phases; it never forces an exit.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == ENTER || state_q == EXIT) && wait_cnt_q != WW'(TIMEOUT_CYCLES)) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    timeout_d = timeout_q | (wait_cnt_d == WW'(TIMEOUT_CYCLES));
  end

  always_comb begin
    flush_req        = (state_q == ENTER) || (state_q == HOLD);
    trigger_ready_o  = (state_q == IDLE);
    flushing_o       = (state_q != IDLE);
    redirect_valid_o = redir_q;
    redirect_pc      = pc_q;
    timeout_o        = timeout_q;
  end

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Bench for hsv_core_flush_ctrl: emulated units with per-unit ack delays, schedule predicted from the
// handshake rules (enter, hold, exit, redirect) as plain cycle arithmetic.
module tb_hsv_core_flush_ctrl;

  localparam int          NU   = 5;
  localparam int          HOLD = 2;
  localparam int          TO   = 64;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          trigger_valid_i;
  logic          trigger_ready_o;
  logic [31:0]   trigger_pc;
  logic          flush_req;
  logic [NU-1:0] flush_ack;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc;
  logic          flushing_o;
  logic          timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdly[NU];
  int fdly[NU];
  int pend[NU];

  hsv_core_flush_ctrl #(
    .NUM_UNITS(NU), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .RESET_PC(RPC)
  ) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .trigger_valid_i(trigger_valid_i), .trigger_ready_o(trigger_ready_o), .trigger_pc(trigger_pc),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .redirect_valid_o(redirect_valid_o), .redirect_pc(redirect_pc),
    .flushing_o(flushing_o), .timeout_o(timeout_o)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Units follow flush_req after their own rise/fall delay; reset forces acks high.
  task automatic tick();
    logic [NU-1:0] nack;
    nack = flush_ack;
    for (int i = 0; i < NU; i++) begin
      if (rst_core) begin
        nack[i] = 1'b1;
        pend[i] = 0;
      end else if (flush_req != flush_ack[i]) begin
        pend[i]++;
        if (pend[i] >= (flush_req ? rdly[i] : fdly[i])) begin
          nack[i] = flush_req;
          pend[i] = 0;
        end
      end else begin
        pend[i] = 0;
      end
    end
    @(posedge clk_core);
    #1;
    flush_ack = nack;
    cyc++;
  endtask

  task automatic set_delays(input int r, input int f);
    for (int i = 0; i < NU; i++) begin
      rdly[i] = r;
      fdly[i] = f;
    end
  endtask

  function automatic int max_arr(input int a[NU]);
    int m = 0;
    for (int i = 0; i < NU; i++) if (a[i] > m) m = a[i];
    return m;
  endfunction

  task automatic test_reset();
    int s, e, l, r;
    rst_core = 1'b1; trigger_valid_i = 1'b0; trigger_pc = '0; flush_ack = '1;
    set_delays(1, 1);
    for (int i = 0; i < NU; i++) pend[i] = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", flush_req); end
      total++; if (trigger_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", trigger_ready_o); end
      total++; if (flushing_o !== 1'b1) begin bad++; $display("FAIL rst_flushing got=%b exp=1", flushing_o); end
      total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b exp=0", redirect_valid_o); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout_o); end
      total++; if (redirect_pc !== RPC) begin bad++; $display("FAIL rst_pc got=%h exp=%h", redirect_pc, RPC); end
    end
    rst_core = 1'b0;
    s = cyc; e = s + HOLD + 1; l = e + max_arr(fdly); r = l + 1;
    while (cyc <= r) begin
      total++; if (flush_req !== (cyc < e)) begin bad++; $display("FAIL post_rst_req cyc=%0d got=%b exp=%b", cyc - s, flush_req, cyc < e); end
      total++; if (redirect_valid_o !== (cyc == r)) begin bad++; $display("FAIL post_rst_rv cyc=%0d got=%b exp=%b", cyc - s, redirect_valid_o, cyc == r); end
      total++; if (flushing_o !== (cyc <= l)) begin bad++; $display("FAIL post_rst_flushing cyc=%0d got=%b exp=%b", cyc - s, flushing_o, cyc <= l); end
      if (cyc == r) begin
        total++; if (redirect_pc !== RPC) begin bad++; $display("FAIL post_rst_pc got=%h exp=%h", redirect_pc, RPC); end
      end
      tick();
    end
    total++; if (trigger_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", trigger_ready_o); end
  endtask

  task automatic test_nominal();
    logic exp_req, exp_rv, exp_rdy;
    set_delays(1, 1);
    trigger_valid_i = 1'b1; trigger_pc = 32'h0000_1000;
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) trigger_valid_i = 1'b0;
      exp_req = (k >= 1 && k <= 4);
      exp_rv  = (k == 7);
      exp_rdy = (k == 0 || k >= 7);
      total++; if (flush_req !== exp_req) begin bad++; $display("FAIL nom_req T+%0d got=%b exp=%b", k, flush_req, exp_req); end
      total++; if (redirect_valid_o !== exp_rv) begin bad++; $display("FAIL nom_rv T+%0d got=%b exp=%b", k, redirect_valid_o, exp_rv); end
      total++; if (trigger_ready_o !== exp_rdy) begin bad++; $display("FAIL nom_ready T+%0d got=%b exp=%b", k, trigger_ready_o, exp_rdy); end
      if (k >= 1) begin
        total++; if (redirect_pc !== 32'h0000_1000) begin bad++; $display("FAIL nom_pc T+%0d got=%h exp=00001000", k, redirect_pc); end
      end
      tick();
    end
  endtask

  task automatic test_stagger();
    int s, e, l, r;
    set_delays(1, 1);
    rdly[3] = 11;
    fdly[0] = 6;
    trigger_valid_i = 1'b1; trigger_pc = 32'h0000_0ABC;
    tick();
    trigger_valid_i = 1'b0;
    s = cyc; e = s + max_arr(rdly) + HOLD + 1; l = e + max_arr(fdly); r = l + 1;
    while (cyc <= r) begin
      total++; if (flush_req !== (cyc < e)) begin bad++; $display("FAIL stag_req cyc=%0d got=%b exp=%b", cyc - s, flush_req, cyc < e); end
      total++; if (redirect_valid_o !== (cyc == r)) begin bad++; $display("FAIL stag_rv cyc=%0d got=%b exp=%b", cyc - s, redirect_valid_o, cyc == r); end
      total++; if (flushing_o !== (cyc <= l)) begin bad++; $display("FAIL stag_flushing cyc=%0d got=%b exp=%b", cyc - s, flushing_o, cyc <= l); end
      tick();
    end
    total++; if (redirect_pc !== 32'h0000_0ABC) begin bad++; $display("FAIL stag_pc got=%h exp=00000abc", redirect_pc); end
  endtask

  task automatic test_random();
    int s, e, l, r, gap;
    logic [31:0] pc;
    for (int it = 0; it < 25; it++) begin
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        total++; if (trigger_ready_o !== 1'b1 || flush_req !== 1'b0) begin bad++; $display("FAIL rnd_idle it=%0d got rdy=%b req=%b exp rdy=1 req=0", it, trigger_ready_o, flush_req); end
        tick();
      end
      for (int i = 0; i < NU; i++) begin
        rdly[i] = $urandom_range(6, 1);
        fdly[i] = $urandom_range(6, 1);
      end
      pc = $urandom;
      trigger_valid_i = 1'b1; trigger_pc = pc;
      tick();
      trigger_valid_i = 1'b0; trigger_pc = ~pc;
      s = cyc; e = s + max_arr(rdly) + HOLD + 1; l = e + max_arr(fdly); r = l + 1;
      while (cyc <= r) begin
        total++; if (flush_req !== (cyc < e)) begin bad++; $display("FAIL rnd_req it=%0d cyc=%0d got=%b exp=%b", it, cyc - s, flush_req, cyc < e); end
        total++; if (redirect_valid_o !== (cyc == r)) begin bad++; $display("FAIL rnd_rv it=%0d cyc=%0d got=%b exp=%b", it, cyc - s, redirect_valid_o, cyc == r); end
        total++; if (trigger_ready_o !== (cyc > l)) begin bad++; $display("FAIL rnd_ready it=%0d cyc=%0d got=%b exp=%b", it, cyc - s, trigger_ready_o, cyc > l); end
        total++; if (redirect_pc !== pc) begin bad++; $display("FAIL rnd_pc it=%0d cyc=%0d got=%h exp=%h", it, cyc - s, redirect_pc, pc); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rv;
    set_delays(1, 1);
    trigger_valid_i = 1'b1; trigger_pc = 32'h0000_3000;
    tick();
    trigger_pc = 32'h0000_2000;
    for (int k = 1; k <= 14; k++) begin
      if (k == 8) trigger_valid_i = 1'b0;
      exp_rv = (k == 7 || k == 14);
      total++; if (redirect_valid_o !== exp_rv) begin bad++; $display("FAIL b2b_rv T+%0d got=%b exp=%b", k, redirect_valid_o, exp_rv); end
      if (k <= 7) begin
        total++; if (trigger_ready_o !== (k == 7)) begin bad++; $display("FAIL b2b_ready T+%0d got=%b exp=%b", k, trigger_ready_o, k == 7); end
        total++; if (redirect_pc !== 32'h0000_3000) begin bad++; $display("FAIL b2b_pc1 T+%0d got=%h exp=00003000", k, redirect_pc); end
      end else begin
        total++; if (redirect_pc !== 32'h0000_2000) begin bad++; $display("FAIL b2b_pc2 T+%0d got=%h exp=00002000", k, redirect_pc); end
        total++; if (flush_req !== (k <= 11)) begin bad++; $display("FAIL b2b_req T+%0d got=%b exp=%b", k, flush_req, k <= 11); end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int waited;
    set_delays(1, 1);
    rdly[2] = 1_000_000;
    trigger_valid_i = 1'b1; trigger_pc = 32'h0000_4000;
    tick();
    trigger_valid_i = 1'b0;
    for (int k = 0; k < 80; k++) begin
      total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL to_req k=%0d got=%b exp=1", k, flush_req); end
      if (k <= 62) begin
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_early k=%0d got=%b exp=0", k, timeout_o); end
      end else if (k >= 66) begin
        total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_set k=%0d got=%b exp=1", k, timeout_o); end
      end
      tick();
    end
    rdly[2] = 1;
    waited = 0;
    while (redirect_valid_o !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL to_recover got rv=%b after %0d cycles exp=1", redirect_valid_o, waited); end
    total++; if (redirect_pc !== 32'h0000_4000) begin bad++; $display("FAIL to_pc got=%h exp=00004000", redirect_pc); end
    tick();
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_o); end
  endtask

  task automatic test_reset_mid();
    int s, r;
    set_delays(1, 1);
    trigger_valid_i = 1'b1; trigger_pc = 32'h0000_5000;
    tick();
    trigger_valid_i = 1'b0;
    tick(); tick();
    total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL mid_hold_req got=%b exp=1", flush_req); end
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    total++; if (flush_req !== 1'b1 || flushing_o !== 1'b1 || trigger_ready_o !== 1'b0) begin
      bad++; $display("FAIL mid_state got req=%b fl=%b rdy=%b exp 1 1 0", flush_req, flushing_o, trigger_ready_o);
    end
    total++; if (redirect_pc !== RPC) begin bad++; $display("FAIL mid_pc got=%h exp=%h", redirect_pc, RPC); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%b exp=0", timeout_o); end
    s = cyc; r = s + HOLD + 1 + 1 + 1;
    while (cyc <= r + 2) begin
      total++; if (redirect_valid_o !== (cyc == r)) begin bad++; $display("FAIL mid_rv cyc=%0d got=%b exp=%b", cyc - s, redirect_valid_o, cyc == r); end
      total++; if (redirect_pc !== RPC) begin bad++; $display("FAIL mid_pc_hold cyc=%0d got=%h exp=%h", cyc - s, redirect_pc, RPC); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stagger();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
